// File: rtl/cpu_datapath_pkg.sv
// Shared types for the bus datapath: ALU op codes, CON condition codes, reset constants.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_datapath_pkg;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_AND,
    ALU_OR,
    ALU_ADD,
    ALU_SUB,
    ALU_MUL,
    ALU_DIV,
    ALU_SHR,
    ALU_SHRA,
    ALU_SHL,
    ALU_ROR,
    ALU_ROL,
    ALU_NEG,
    ALU_NOT
  } alu_op_t;

  typedef enum logic [1:0] {
    CON_EQ = 2'b00,
    CON_NE = 2'b01,
    CON_GE = 2'b10,
    CON_LT = 2'b11
  } con_cond_t;

  localparam logic [31:0] WORD_RESET = 32'h0000_0000;
  localparam logic [63:0] DWORD_RESET = 64'h0;

  function automatic logic [31:0] sign_ext19(input logic [18:0] v);
    return {{13{v[18]}}, v};
  endfunction

  function automatic logic con_eval(input con_cond_t cond, input logic [31:0] v);
    logic res;
    case (cond)
      CON_EQ:  res = (v == 32'h0);
      CON_NE:  res = (v != 32'h0);
      CON_GE:  res = ~v[31];
      default: res = v[31];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU: A = Y register, B = bus, 64-bit result for the Z register.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module cpu_alu
  import cpu_datapath_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic [4:0]         sh;
  logic signed [63:0] prod;
  logic signed [31:0] quot;
  logic signed [31:0] rem;

  assign sh   = b[4:0];
  assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  always_comb begin
    quot = '0;
    rem  = '0;
    if (b != 32'h0) begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end
  end

  always_comb begin
    result = DWORD_RESET;
    case (op)
      ALU_AND:  result = {32'h0, a & b};
      ALU_OR:   result = {32'h0, a | b};
      ALU_ADD:  result = {32'h0, a + b};
      ALU_SUB:  result = {32'h0, a - b};
      ALU_MUL:  result = prod;
      ALU_DIV:  result = {rem, quot};
      ALU_SHR:  result = {32'h0, a >> sh};
      ALU_SHRA: result = {32'h0, $signed(a) >>> sh};
      ALU_SHL:  result = {32'h0, a << sh};
      // A shift by 32 yields 0, so a rotate by 0 returns A unchanged.
      ALU_ROR:  result = {32'h0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
      ALU_ROL:  result = {32'h0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
      ALU_NEG:  result = {32'h0, 32'h0 - b};
      ALU_NOT:  result = {32'h0, ~b};
      default:  result = DWORD_RESET;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// Bus-based 32-bit course-processor datapath: register file, special registers, ALU, RAM, I/O.
// Latency: one control step per clock; memory reads are combinational into MDR.
// Backpressure: none; every micro-op completes on the edge it is issued.
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int    MEM_DEPTH = 512,
  parameter string MEM_FILE  = "memory.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCout,
  input  logic        IRout,
  input  logic        MDRout,
  input  logic        INout,
  input  logic        Cout,
  input  logic        Yout,
  input  logic        MARout,
  input  logic        Read,
  input  logic        IncPC,
  input  logic        AND,
  input  logic        OR,
  input  logic        ADD,
  input  logic        SUB,
  input  logic        MUL,
  input  logic        DIV,
  input  logic        SHR,
  input  logic        SHRA,
  input  logic        SHL,
  input  logic        ROR,
  input  logic        ROL,
  input  logic        NEG,
  input  logic        NOT,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        Zin,
  input  logic        Yin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        CONin,
  input  logic        OUT_Portin,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic        CON_RESET,
  input  logic        PCSave,
  input  logic [31:0] IN_unit_input,
  output logic [31:0] OUT_unit_output
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0] regs [16];
  logic [31:0] pc, ir, mar, mdr, hi, lo, y, in_reg, out_reg;
  logic [63:0] z;
  logic        con;

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] mem_rd_dat;
  logic [31:0] bus_dat;
  logic [31:0] c_dat;
  logic [3:0]  reg_sel;
  logic        bus_active;
  alu_op_t     alu_op;
  logic [63:0] alu_z;
  logic        unused_ok;

  assign c_dat      = sign_ext19(ir[18:0]);
  assign reg_sel    = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign mem_rd_dat = mem[mar[AW-1:0]];
  assign bus_active = |{HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout,
                        INout, Cout, Yout, MARout, Rout, BAout};
  assign unused_ok  = ^{ir[31:27], mar};

  always_comb begin
    bus_dat = WORD_RESET;
    if      (HIout)    bus_dat = hi;
    else if (LOout)    bus_dat = lo;
    else if (Zhighout) bus_dat = z[63:32];
    else if (Zlowout)  bus_dat = z[31:0];
    else if (PCout)    bus_dat = pc;
    else if (IRout)    bus_dat = ir;
    else if (MDRout)   bus_dat = mdr;
    else if (INout)    bus_dat = in_reg;
    else if (Cout)     bus_dat = c_dat;
    else if (Yout)     bus_dat = y;
    else if (MARout)   bus_dat = mar;
    else if (Rout)     bus_dat = regs[reg_sel];
    else if (BAout)    bus_dat = (reg_sel == 4'd0) ? WORD_RESET : regs[reg_sel];
  end

  // One-hot op selects, resolved in port order should several be raised together.
  always_comb begin
    alu_op = ALU_NONE;
    if      (AND)  alu_op = ALU_AND;
    else if (OR)   alu_op = ALU_OR;
    else if (ADD)  alu_op = ALU_ADD;
    else if (SUB)  alu_op = ALU_SUB;
    else if (MUL)  alu_op = ALU_MUL;
    else if (DIV)  alu_op = ALU_DIV;
    else if (SHR)  alu_op = ALU_SHR;
    else if (SHRA) alu_op = ALU_SHRA;
    else if (SHL)  alu_op = ALU_SHL;
    else if (ROR)  alu_op = ALU_ROR;
    else if (ROL)  alu_op = ALU_ROL;
    else if (NEG)  alu_op = ALU_NEG;
    else if (NOT)  alu_op = ALU_NOT;
  end

  cpu_alu u_alu (
    .op     (alu_op),
    .a      (y),
    .b      (bus_dat),
    .result (alu_z)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= WORD_RESET;
      pc      <= WORD_RESET;
      ir      <= WORD_RESET;
      mar     <= WORD_RESET;
      mdr     <= WORD_RESET;
      hi      <= WORD_RESET;
      lo      <= WORD_RESET;
      y       <= WORD_RESET;
      z       <= DWORD_RESET;
      in_reg  <= WORD_RESET;
      out_reg <= WORD_RESET;
      con     <= 1'b0;
    end else begin
      in_reg <= IN_unit_input;
      if (Rin)    regs[reg_sel] <= bus_dat;
      // Link write is last so it overrides an Rin aimed at R15.
      if (PCSave) regs[15] <= pc;
      if (PCin)   pc  <= IncPC ? pc + 32'd1 : bus_dat;
      if (MARin)  mar <= IncPC ? pc : bus_dat;
      if (IRin)   ir  <= bus_dat;
      if (MDRin)  mdr <= (Read | read_mem) ? mem_rd_dat : bus_dat;
      if (Yin)    y   <= bus_dat;
      if (Zin)    z   <= alu_z;
      // Without a bus source, HI/LO capture the mul/div result halves from Z.
      if (HIin)   hi  <= bus_active ? bus_dat : z[63:32];
      if (LOin)   lo  <= bus_active ? bus_dat : z[31:0];
      if (CON_RESET)  con <= 1'b0;
      else if (CONin) con <= con_eval(con_cond_t'(ir[20:19]), bus_dat);
      if (OUT_Portin) out_reg <= bus_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (write_mem) mem[mar[AW-1:0]] <= mdr;
  end

  assign OUT_unit_output = out_reg;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed program, ALU vector table, random ALU vs model.
module tb_cpu_datapath;
  localparam int C_HIOUT = 0, C_LOOUT = 1, C_ZHOUT = 2, C_ZLOUT = 3, C_PCOUT = 4, C_IROUT = 5,
                 C_MDROUT = 6, C_INOUT = 7, C_COUT = 8, C_YOUT = 9, C_MAROUT = 10, C_READ = 11,
                 C_INCPC = 12, C_ALU0 = 13, C_GRA = 26, C_GRB = 27, C_GRC = 28, C_RIN = 29,
                 C_ROUT = 30, C_BAOUT = 31, C_HIIN = 32, C_LOIN = 33, C_PCIN = 34, C_IRIN = 35,
                 C_ZIN = 36, C_YIN = 37, C_MARIN = 38, C_MDRIN = 39, C_CONIN = 40, C_OUTIN = 41,
                 C_RDMEM = 42, C_WRMEM = 43, C_CONRST = 44, C_PCSAVE = 45;
  localparam int OP_MUL = 4, OP_DIV = 5, OP_ADD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] ctl = '0;
  logic [31:0] in_dat = '0;
  logic [31:0] out_dat;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cpu_datapath #(.MEM_DEPTH(512), .MEM_FILE("")) dut (
    .clk(clk), .reset(reset),
    .HIout(ctl[C_HIOUT]), .LOout(ctl[C_LOOUT]), .Zhighout(ctl[C_ZHOUT]), .Zlowout(ctl[C_ZLOUT]),
    .PCout(ctl[C_PCOUT]), .IRout(ctl[C_IROUT]), .MDRout(ctl[C_MDROUT]), .INout(ctl[C_INOUT]),
    .Cout(ctl[C_COUT]), .Yout(ctl[C_YOUT]), .MARout(ctl[C_MAROUT]), .Read(ctl[C_READ]),
    .IncPC(ctl[C_INCPC]),
    .AND(ctl[C_ALU0+0]), .OR(ctl[C_ALU0+1]), .ADD(ctl[C_ALU0+2]), .SUB(ctl[C_ALU0+3]),
    .MUL(ctl[C_ALU0+4]), .DIV(ctl[C_ALU0+5]), .SHR(ctl[C_ALU0+6]), .SHRA(ctl[C_ALU0+7]),
    .SHL(ctl[C_ALU0+8]), .ROR(ctl[C_ALU0+9]), .ROL(ctl[C_ALU0+10]), .NEG(ctl[C_ALU0+11]),
    .NOT(ctl[C_ALU0+12]),
    .Gra(ctl[C_GRA]), .Grb(ctl[C_GRB]), .Grc(ctl[C_GRC]), .Rin(ctl[C_RIN]), .Rout(ctl[C_ROUT]),
    .BAout(ctl[C_BAOUT]), .HIin(ctl[C_HIIN]), .LOin(ctl[C_LOIN]), .PCin(ctl[C_PCIN]),
    .IRin(ctl[C_IRIN]), .Zin(ctl[C_ZIN]), .Yin(ctl[C_YIN]), .MARin(ctl[C_MARIN]),
    .MDRin(ctl[C_MDRIN]), .CONin(ctl[C_CONIN]), .OUT_Portin(ctl[C_OUTIN]),
    .read_mem(ctl[C_RDMEM]), .write_mem(ctl[C_WRMEM]), .CON_RESET(ctl[C_CONRST]),
    .PCSave(ctl[C_PCSAVE]), .IN_unit_input(in_dat), .OUT_unit_output(out_dat)
  );

  function automatic logic [63:0] b(input int i);
    return 64'd1 << i;
  endfunction

  // One control step: hold the selects across one rising edge, return 1 time unit after it.
  task automatic cyc(input logic [63:0] m);
    ctl = m;
    @(posedge clk);
    #1;
    ctl = '0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // IN register samples the pin every cycle, so a value needs one edge before INout.
  task automatic drive_in(input logic [31:0] v);
    in_dat = v;
    cyc('0);
  endtask

  task automatic set_ir(input logic [31:0] v);
    drive_in(v);
    cyc(b(C_INOUT) | b(C_IRIN));
  endtask

  task automatic observe(input logic [63:0] src, output logic [31:0] v);
    cyc(src | b(C_OUTIN));
    v = out_dat;
  endtask

  task automatic read_reg(input int n, output logic [31:0] v);
    set_ir({5'd0, 4'(n), 23'd0});
    observe(b(C_GRA) | b(C_ROUT), v);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    drive_in(addr);
    cyc(b(C_INOUT) | b(C_MARIN));
    drive_in(data);
    cyc(b(C_INOUT) | b(C_MDRIN));
    cyc(b(C_WRMEM));
  endtask

  task automatic fetch();
    cyc(b(C_INCPC) | b(C_MARIN) | b(C_PCIN));
    cyc(b(C_READ) | b(C_MDRIN));
    cyc(b(C_MDROUT) | b(C_IRIN));
  endtask

  task automatic ldi();
    fetch();
    cyc(b(C_GRB) | b(C_BAOUT) | b(C_YIN));
    cyc(b(C_COUT) | b(C_ALU0 + OP_ADD) | b(C_ZIN));
    cyc(b(C_ZLOUT) | b(C_GRA) | b(C_RIN));
  endtask

  task automatic alu_run(input int op, input logic [31:0] a, input logic [31:0] bb,
                         output logic [63:0] zr);
    logic [31:0] lo_v, hi_v;
    drive_in(a);
    cyc(b(C_INOUT) | b(C_YIN));
    drive_in(bb);
    cyc(b(C_INOUT) | b(C_ALU0 + op) | b(C_ZIN));
    observe(b(C_ZLOUT), lo_v);
    observe(b(C_ZHOUT), hi_v);
    zr = {hi_v, lo_v};
  endtask

  // Reference: ops 0..12 = AND OR ADD SUB MUL DIV SHR SHRA SHL ROR ROL NEG NOT.
  function automatic logic [63:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] bb);
    int          ia, ib, n;
    longint      p;
    logic [63:0] d;
    logic [31:0] fill;
    ia = a;
    ib = bb;
    n  = int'(bb % 32);
    case (op)
      0: return {32'h0, a & bb};
      1: return {32'h0, a | bb};
      2: return {32'h0, a + bb};
      3: return {32'h0, a - bb};
      4: begin p = longint'(ia) * longint'(ib); return p; end
      5: begin
        if (ib == 0) return 64'h0;
        return {32'(ia % ib), 32'(ia / ib)};
      end
      6: return {32'h0, a >> n};
      7: begin
        fill = a[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0;
        return {32'h0, (a >> n) | fill};
      end
      8: return {32'h0, a << n};
      9: begin d = {a, a} >> n; return {32'h0, d[31:0]}; end
      10: begin d = {a, a} << n; return {32'h0, d[63:32]}; end
      11: return {32'h0, 32'h0 - bb};
      default: return {32'h0, ~bb};
    endcase
  endfunction

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] bb;
    logic [63:0] z;
  } alu_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_vec_t    vecs [16];
    logic [31:0] v;
    logic [63:0] zr;

    vecs[0]  = '{2,  32'h7FFF_FFFF, 32'h0000_0001, 64'h0000_0000_8000_0000};
    vecs[1]  = '{3,  32'h0000_0003, 32'h0000_0005, 64'h0000_0000_FFFF_FFFE};
    vecs[2]  = '{0,  32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000};
    vecs[3]  = '{1,  32'h0F0F_0000, 32'h0000_00F0, 64'h0000_0000_0F0F_00F0};
    vecs[4]  = '{4,  32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000};
    vecs[5]  = '{4,  32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[6]  = '{5,  32'hFFFF_FFEF, 32'h0000_0005, 64'hFFFF_FFFE_FFFF_FFFD};
    vecs[7]  = '{5,  32'h0000_0011, 32'h0000_0000, 64'h0};
    vecs[8]  = '{6,  32'h8000_0000, 32'h0000_001F, 64'h0000_0000_0000_0001};
    vecs[9]  = '{7,  32'h8000_0000, 32'h0000_001F, 64'h0000_0000_FFFF_FFFF};
    vecs[10] = '{7,  32'h8000_0010, 32'h0000_0023, 64'h0000_0000_F000_0002};
    vecs[11] = '{8,  32'h0000_0001, 32'h0000_0020, 64'h0000_0000_0000_0001};
    vecs[12] = '{9,  32'h0000_0001, 32'h0000_0001, 64'h0000_0000_8000_0000};
    vecs[13] = '{10, 32'h8000_0001, 32'h0000_0004, 64'h0000_0000_0000_0018};
    vecs[14] = '{11, 32'h1234_5678, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
    vecs[15] = '{12, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_FFFF_FFFF};

    // Program RAM through the datapath, then reset: RAM must survive reset.
    reset = 1'b1;
    cyc('0);
    reset = 1'b0;
    write_word(32'd0, 32'h0107_FFFB);
    write_word(32'd1, 32'h0180_0006);
    write_word(32'd2, 32'h0118_0000);
    write_word(32'd3, 32'h0200_0000);
    drive_in(32'h0000_1111);
    cyc(b(C_INOUT) | b(C_OUTIN));
    reset = 1'b1;
    cyc('0);
    cyc('0);
    reset = 1'b0;
    check("reset_out", out_dat, 64'h0);
    observe(b(C_PCOUT), v);
    check("reset_pc", v, 64'h0);
    observe(b(C_MAROUT), v);
    check("reset_mar", v, 64'h0);
    observe(b(C_ZHOUT), v);
    check("reset_zhi", v, 64'h0);

    // ldi R2,-5 ; ldi R3,6 ; mul R2,R3 ; mfhi R4
    ldi();
    ldi();
    observe(b(C_PCOUT), v);
    check("pc_after_ldi", v, 64'd2);
    fetch();
    cyc(b(C_GRB) | b(C_ROUT) | b(C_YIN));
    cyc(b(C_GRA) | b(C_ROUT) | b(C_ALU0 + OP_MUL) | b(C_ZIN));
    cyc(b(C_HIIN) | b(C_LOIN));
    fetch();
    cyc(b(C_HIOUT) | b(C_GRA) | b(C_RIN));
    observe(b(C_PCOUT), v);
    check("pc_after_mfhi", v, 64'd4);
    observe(b(C_HIOUT), v);
    check("mul_hi", v, 64'hFFFF_FFFF);
    observe(b(C_LOOUT), v);
    check("mul_lo", v, 64'hFFFF_FFE2);
    read_reg(2, v);
    check("ldi_r2", v, 64'hFFFF_FFFB);
    read_reg(3, v);
    check("ldi_r3", v, 64'h6);
    read_reg(4, v);
    check("mfhi_r4", v, 64'hFFFF_FFFF);

    // HI loads the bus, not Z, when a bus source is active.
    drive_in(32'h0000_0055);
    cyc(b(C_INOUT) | b(C_HIIN));
    observe(b(C_HIOUT), v);
    check("hi_from_bus", v, 64'h55);

    // R0 is writable, but BAout reads it as zero.
    set_ir(32'h0);
    drive_in(32'h0000_00AB);
    cyc(b(C_INOUT) | b(C_GRA) | b(C_RIN));
    observe(b(C_GRA) | b(C_ROUT), v);
    check("r0_rout", v, 64'hAB);
    observe(b(C_GRA) | b(C_BAOUT), v);
    check("r0_baout", v, 64'h0);

    // PCSave beats Rin on R15.
    drive_in(32'h0000_0777);
    cyc(b(C_INOUT) | b(C_PCIN));
    set_ir({5'd0, 4'd15, 23'd0});
    drive_in(32'h1234_5678);
    cyc(b(C_INOUT) | b(C_GRA) | b(C_RIN) | b(C_PCSAVE));
    read_reg(15, v);
    check("pcsave_r15", v, 64'h777);

    // read_mem strobe reads RAM like Read.
    drive_in(32'd1);
    cyc(b(C_INOUT) | b(C_MARIN));
    cyc(b(C_RDMEM) | b(C_MDRIN));
    observe(b(C_MDROUT), v);
    check("read_mem_strobe", v, 64'h0180_0006);

    // DIV and divide-by-zero, then no-op Zin clears Z.
    alu_run(OP_DIV, 32'd17, 32'd5, zr);
    check("div_17_5", zr, 64'h0000_0002_0000_0003);
    drive_in(32'd17);
    cyc(b(C_INOUT) | b(C_YIN));
    cyc(b(C_ALU0 + OP_DIV) | b(C_ZIN));
    observe(b(C_ZLOUT), v);
    check("div0_lo", v, 64'h0);
    observe(b(C_ZHOUT), v);
    check("div0_hi", v, 64'h0);
    alu_run(OP_ADD, 32'd3, 32'd4, zr);
    cyc(b(C_ZIN));
    observe(b(C_ZLOUT), v);
    check("noop_z_clear", v, 64'h0);

    // CON with IR[20:19] = 01 (!= 0).
    set_ir(32'h0008_0000);
    drive_in(32'd7);
    cyc(b(C_INOUT) | b(C_CONIN));
    check("con_ne_7", 64'(dut.con), 64'h1);
    drive_in(32'd0);
    cyc(b(C_INOUT) | b(C_CONIN));
    check("con_ne_0", 64'(dut.con), 64'h0);
    drive_in(32'd7);
    cyc(b(C_INOUT) | b(C_CONIN));
    cyc(b(C_CONRST));
    check("con_reset", 64'(dut.con), 64'h0);
    cyc(b(C_INOUT) | b(C_CONIN) | b(C_CONRST));
    check("con_reset_wins", 64'(dut.con), 64'h0);
    set_ir(32'h0018_0000);
    drive_in(32'h8000_0000);
    cyc(b(C_INOUT) | b(C_CONIN));
    check("con_lt", 64'(dut.con), 64'h1);

    for (int i = 0; i < 16; i++) begin
      alu_run(vecs[i].op, vecs[i].a, vecs[i].bb, zr);
      check($sformatf("alu_vec%0d_op%0d", i, vecs[i].op), zr, vecs[i].z);
    end

    for (int i = 0; i < 60; i++) begin
      int          op;
      logic [31:0] ra, rb;
      op = int'($urandom_range(0, 12));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = rb & 32'h0000_003F;
      if (op == OP_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      alu_run(op, ra, rb, zr);
      check($sformatf("alu_rand%0d_op%0d", i, op), zr, alu_model(op, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
